// File: rtl/tfhe_host_rd_dma.sv
// AXI4 read-burst DMA: fetches a host region on start_pbs and streams the beats
// straight into the PBS input buffer, one burst outstanding at a time.
module tfhe_host_rd_dma #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          start_pbs,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [31:0]                   host_wr_len,
    output logic                          dma_busy,
    output logic                          dma_done,
    output logic                          dma_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int BB = C_M_AXI_DATA_WIDTH / 8;
    localparam int SZ = $clog2(BB);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [31:0]   rem;
    logic [31:0]   beats;
    logic [31:0]   burst_n;
    logic [7:0]    arlen;
    logic          arvalid;
    logic [31:0]   page_beats;
    logic [31:0]   n;
    logic          misaligned;
    logic          in_data;
    logic          hs;

    // ARPROT/ARCACHE are not ported; the interconnect sees them tied to zero.
    assign M_AXI_ARSIZE  = 3'(SZ);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = arlen;
    assign M_AXI_ARVALID = arvalid;

    // Unbuffered pass-through: the R channel is stalled directly by m_ready.
    assign in_data      = (state == DATA);
    assign M_AXI_RREADY = in_data && m_ready;
    assign m_valid      = in_data && M_AXI_RVALID;
    assign m_data       = in_data ? M_AXI_RDATA : '0;
    assign m_last       = m_valid && (rem == 32'd1);
    assign hs           = in_data && M_AXI_RVALID && m_ready;

    assign misaligned = (|host_wr_addr[SZ-1:0]) || (|host_wr_len[SZ-1:0]);

    // Burst size is clipped so a burst never crosses a 4 KB page.
    always_comb begin
        page_beats = (32'd4096 - {20'd0, addr[11:0]}) >> SZ;
        n = rem;
        if (n > 32'(C_MAX_BURST_LEN)) n = 32'(C_MAX_BURST_LEN);
        if (n > page_beats) n = page_beats;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            beats    <= '0;
            burst_n  <= '0;
            arlen    <= '0;
            arvalid  <= 1'b0;
            dma_busy <= 1'b0;
            dma_done <= 1'b0;
            dma_err  <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pbs) begin
                        addr     <= host_wr_addr;
                        rem      <= host_wr_len >> SZ;
                        dma_busy <= 1'b1;
                        dma_err  <= misaligned;
                        if (misaligned || (host_wr_len >> SZ) == 32'd0) begin
                            state    <= DONE;
                            dma_done <= 1'b1;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    // First cycle computes and registers the burst; then hold until accepted.
                    if (!arvalid) begin
                        arvalid <= 1'b1;
                        arlen   <= 8'(n - 32'd1);
                        burst_n <= n;
                    end else if (M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                        beats   <= burst_n;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (hs) begin
                        rem   <= rem - 32'd1;
                        beats <= beats - 32'd1;
                        if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != (beats == 32'd1))
                            dma_err <= 1'b1;
                        if (beats == 32'd1) begin
                            addr <= addr + AW'(burst_n << SZ);
                            if (rem == 32'd1) begin
                                state    <= DONE;
                                dma_done <= 1'b1;
                            end else begin
                                state <= ADDR;
                            end
                        end
                    end
                end
                DONE: begin
                    dma_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tfhe_host_rd_dma.sv
// Bench for tfhe_host_rd_dma: AXI read slave + memory model, stream sink, and a
// burst-splitting reference model computed from the transfer rules.
module tb_tfhe_host_rd_dma;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] waddr, wlen;
    logic        busy, done, err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [63:0] m_data;
    logic        m_valid, m_last, m_ready;

    always #5 clk = ~clk;

    tfhe_host_rd_dma dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start_pbs(start),
        .host_wr_addr(waddr), .host_wr_len(wlen),
        .dma_busy(busy), .dma_done(done), .dma_err(err),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    typedef struct { logic [31:0] a; int n; } burst_t;
    typedef struct { logic [31:0] a; logic [31:0] len; int nb; int arlen0; bit err; } vec_t;

    int checks = 0, errors = 0, cyc = 0;
    burst_t      got_ar[$], exp_ar[$];
    logic [63:0] got_d[$];
    int got_last_cnt, got_last_idx, done_cnt, done_cyc, last_hs_cyc, first_arv_cyc;
    logic err_at_done;
    int rdy_pct = 100, rv_pct = 100, ar_max = 0, err_beat = -1;
    logic [31:0] exp_a0;
    int exp_n, s_cyc;
    bit exp_mis;

    logic        sb_busy, rv_hold, prev_pend;
    logic [31:0] b_addr;
    int          b_len, b_idx, ar_wait, xbeat;
    logic [39:0] prev_ar;

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    initial forever begin @(posedge clk); cyc++; end

    // Slave/sink: inputs driven on negedge, handshakes observed #1 later (they fire on the next posedge).
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; m_ready = 0;
        sb_busy = 0; rv_hold = 0; prev_pend = 0; prev_ar = 0;
        b_addr = 0; b_len = 0; b_idx = 0; ar_wait = 0; xbeat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
                sb_busy = 0; rv_hold = 0; prev_pend = 0; ar_wait = 0;
            end else begin
                arready = arvalid && !sb_busy && ar_wait == 0;
                if (arvalid && !sb_busy && ar_wait > 0) ar_wait--;
                if (!sb_busy) rvalid = 0;
                else if (!rv_hold) rvalid = ($urandom_range(99) < 32'(rv_pct));
                rdata = mem(b_addr + 32'(b_idx * 8));
                rlast = sb_busy && (b_idx == b_len - 1);
                rresp = (xbeat == err_beat) ? 2'b10 : 2'b00;
                m_ready = ($urandom_range(99) < 32'(rdy_pct));
                #1;
                if (!rst) begin
                    if (prev_pend) chk("ar_hold", {arvalid, araddr, arlen}, {1'b1, prev_ar});
                    prev_pend = arvalid && !arready;
                    prev_ar = {araddr, arlen};
                    if (arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
                    if (arvalid && arready) begin
                        got_ar.push_back('{araddr, int'(arlen) + 1});
                        sb_busy = 1; b_addr = araddr; b_len = int'(arlen) + 1; b_idx = 0;
                        ar_wait = $urandom_range(ar_max);
                    end
                    if (m_valid && m_ready) begin
                        got_d.push_back(m_data);
                        if (m_last) begin got_last_cnt++; got_last_idx = got_d.size() - 1; end
                        last_hs_cyc = cyc;
                    end
                    if (rvalid && rready) begin
                        b_idx++; xbeat++;
                        if (b_idx == b_len) sb_busy = 0;
                    end
                    rv_hold = rvalid && !rready;
                    if (done) begin done_cnt++; done_cyc = cyc; err_at_done = err; end
                end
            end
        end
    end

    // Reference: split into bursts by remaining beats, max burst length and 4 KB page limit.
    task automatic build_model(input logic [31:0] a, input logic [31:0] len);
        int rem, pg, n;
        exp_ar.delete();
        exp_a0 = a;
        exp_mis = (a % 8 != 0) || (len % 8 != 0);
        exp_n = exp_mis ? 0 : int'(len / 8);
        rem = exp_n;
        while (rem > 0) begin
            pg = (4096 - int'(a % 4096)) / 8;
            n = rem;
            if (n > 16) n = 16;
            if (n > pg) n = pg;
            exp_ar.push_back('{a, n});
            a = a + 32'(n * 8);
            rem -= n;
        end
    endtask

    task automatic clear_obs();
        got_ar.delete(); got_d.delete();
        got_last_cnt = 0; got_last_idx = -1; done_cnt = 0; done_cyc = -1;
        last_hs_cyc = -1; first_arv_cyc = -1; err_at_done = 0; xbeat = 0;
        ar_wait = $urandom_range(ar_max);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] len);
        @(negedge clk);
        clear_obs();
        build_model(a, len);
        start = 1; waddr = a; wlen = len; s_cyc = cyc;
        @(negedge clk);
        start = 0;
        #2;
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, exp_mis);
    endtask

    task automatic finish_xfer();
        int t, bad;
        bit eerr;
        t = 0;
        while (done_cnt == 0 && t < 5000) begin @(negedge clk); t++; end
        if (done_cnt == 0) begin chk("done_timeout", 0, 1); return; end
        repeat (3) @(negedge clk);
        #2;
        eerr = exp_mis || (err_beat >= 0 && err_beat < exp_n);
        chk("done_cnt", done_cnt, 1);
        chk("busy_after_done", busy, 0);
        chk("err_at_done", err_at_done, eerr);
        chk("nbursts", got_ar.size(), exp_ar.size());
        for (int i = 0; i < got_ar.size() && i < exp_ar.size(); i++) begin
            chk("ar_addr", got_ar[i].a, exp_ar[i].a);
            chk("ar_len", got_ar[i].n, exp_ar[i].n);
        end
        chk("nbeats", got_d.size(), exp_n);
        bad = 0;
        for (int i = 0; i < got_d.size() && i < exp_n; i++)
            if (got_d[i] !== mem(exp_a0 + 32'(i * 8))) bad++;
        chk("data_bad_beats", bad, 0);
        chk("last_cnt", got_last_cnt, (exp_n > 0) ? 1 : 0);
        if (exp_n > 0) begin
            chk("last_idx", got_last_idx, exp_n - 1);
            chk("start_to_arvalid", first_arv_cyc, s_cyc + 2);
            chk("last_to_done", done_cyc, last_hs_cyc + 1);
        end else begin
            chk("no_ar", first_arv_cyc, -1);
            chk("start_to_done", done_cyc, s_cyc + 1);
        end
    endtask

    initial begin
        vec_t tbl[9];
        int t;
        tbl[0] = '{32'h0000_1000, 32'd256, 2, 15, 1'b0};
        tbl[1] = '{32'h0000_0FF0, 32'd64,  2, 1,  1'b0};
        tbl[2] = '{32'h0000_0000, 32'd0,   0, 0,  1'b0};
        tbl[3] = '{32'h0000_1004, 32'd64,  0, 0,  1'b1};
        tbl[4] = '{32'h0000_2000, 32'd12,  0, 0,  1'b1};
        tbl[5] = '{32'h0000_0FF8, 32'd8,   1, 0,  1'b0};
        tbl[6] = '{32'h0000_3000, 32'd200, 2, 15, 1'b0};
        tbl[7] = '{32'hFFFF_FF80, 32'd256, 2, 15, 1'b0};
        tbl[8] = '{32'h0000_0F80, 32'd512, 4, 15, 1'b0};

        rst = 1; start = 0; waddr = 0; wlen = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", {arvalid, rready, m_valid, m_last, busy, done, err, arlen},
            {7'b0, 8'h00});
        chk("reset_addr_data", {araddr, m_data}, '0);
        chk("arsize_arburst", {arsize, arburst}, {3'd3, 2'b01});
        @(negedge clk); rst = 0;

        for (int i = 0; i < 9; i++) begin
            launch(tbl[i].a, tbl[i].len);
            finish_xfer();
            chk("tbl_nbursts", got_ar.size(), tbl[i].nb);
            if (tbl[i].nb > 0 && got_ar.size() > 0) chk("tbl_arlen0", got_ar[0].n - 1, tbl[i].arlen0);
            chk("tbl_err", err_at_done, tbl[i].err);
        end

        // Backpressure on both AR and R/stream paths.
        rdy_pct = 50; rv_pct = 70; ar_max = 3;
        launch(32'h0000_4000, 32'd512); finish_xfer();

        // SLVERR on beat 3 of 8: all beats delivered, error sticky; next start clears it.
        rdy_pct = 100; rv_pct = 100; ar_max = 0; err_beat = 2;
        launch(32'h0000_6000, 32'd64); finish_xfer();
        err_beat = -1;
        launch(32'h0000_7000, 32'd64); finish_xfer();

        // Stray start while busy must not disturb the transfer.
        rdy_pct = 60;
        launch(32'h0000_8000, 32'd128);
        repeat (4) @(negedge clk);
        start = 1; waddr = 32'h0000_9000; wlen = 32'd8;
        @(negedge clk); start = 0;
        finish_xfer();
        rdy_pct = 100;

        // start_pbs held through the dma_done cycle of a zero-length start is ignored.
        @(negedge clk);
        clear_obs();
        start = 1; waddr = 32'h0; wlen = 32'd0;
        @(negedge clk);
        waddr = 32'h0000_1000; wlen = 32'd64;
        @(negedge clk); start = 0;
        repeat (8) @(negedge clk);
        #2;
        chk("overlap_done_cnt", done_cnt, 1);
        chk("overlap_no_ar", first_arv_cyc, -1);
        chk("overlap_idle", busy, 0);

        // Reset during DATA aborts immediately; block then works normally.
        launch(32'h0000_A000, 32'd256);
        t = 0;
        while (got_d.size() < 3 && t < 200) begin @(negedge clk); t++; end
        chk("reached_data", got_d.size() >= 3, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midreset_outs", {arvalid, rready, m_valid, m_last, busy, done, err, arlen},
            {7'b0, 8'h00});
        chk("midreset_addr_data", {araddr, m_data}, '0);
        repeat (3) @(negedge clk);
        rst = 0;
        launch(32'h0000_B000, 32'd64); finish_xfer();

        // Randomized transfers against the reference model.
        for (int k = 0; k < 12; k++) begin
            logic [31:0] a, len;
            rdy_pct = int'($urandom_range(30, 100));
            rv_pct  = int'($urandom_range(50, 100));
            ar_max  = int'($urandom_range(0, 4));
            err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            a = $urandom & 32'h000F_FFF8;
            if ($urandom_range(0, 7) == 0) a = a | 32'd4;
            len = 32'($urandom_range(0, 80) * 8);
            if ($urandom_range(0, 9) == 0) len = len + 32'd3;
            launch(a, len);
            finish_xfer();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time %0t reached, expected summary before it", $time);
        $fatal(1);
    end
endmodule
